fifo_uart_tx: RTL
=================

Name: fifo_uart_tx

Overview:
- Read-side consumer of the controller's byte FIFO.
- Pops bytes using the FIFO's empty/read/read_data handshake and serialises each byte onto a UART TX line: 8N1, LSB first.
- Sits between the response FIFO and the host-facing serial pin, and drains the FIFO back-to-back while data is available.

Parameters:
CLK_FREQ, 25000000, system clock frequency in Hz
BIT_RATE, 115200, UART baud rate in bit/s; CYCLES_PER_BIT = CLK_FREQ / BIT_RATE (integer division, must be >= 2)
PAYLOAD_BITS, 8, data bits per frame; must equal the FIFO WIDTH

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = in reset)
tx_enable  input  1  1 = allowed to start new frames; 0 = finish the current frame, then hold idle
fifo_empty  input  1  FIFO empty flag
fifo_read  output  1  one-cycle pop strobe to the FIFO
fifo_read_data  input  PAYLOAD_BITS  FIFO output data, valid 1 cycle after the fifo_read pulse
uart_tx  output  1  serial line, idle high
busy  output  1  1 from the pop until the end of the stop bit

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, uart_tx=1, fifo_read=0, busy=0.
  - Baud counter, bit index and shift register cleared.
- States and transitions:
  - IDLE -> POP when tx_enable=1 and fifo_empty=0. On entry to POP, fifo_read=1 for exactly one cycle and busy=1.
  - POP -> LOAD: next cycle, fifo_read=0.
  - LOAD: fifo_read_data is captured into the shift register on this cycle. -> START.
  - START: uart_tx=0 for CYCLES_PER_BIT cycles. -> DATA.
  - DATA: uart_tx = shift[0]. Shift right every CYCLES_PER_BIT cycles, PAYLOAD_BITS bits total, LSB first. -> STOP after the last bit.
  - STOP: uart_tx=1 for CYCLES_PER_BIT cycles. At the end, busy=0 and -> IDLE.
- Baud counter:
  - Counts 0..CYCLES_PER_BIT-1 and reloads at every bit boundary.
  - Width is $clog2(CYCLES_PER_BIT); no accumulated drift.
- Frame length: exactly (PAYLOAD_BITS+2)*CYCLES_PER_BIT cycles from the first START cycle to the last STOP cycle.
- Back-to-back: from IDLE with data present, the next START begins 3 cycles after STOP ends (IDLE, POP, LOAD).
- Latency: first START cycle is 3 cycles after fifo_empty falls while idle with tx_enable=1.
- fifo_read is never asserted while fifo_empty=1. At most one pop per frame.
- fifo_empty or fifo_read_data changing mid-frame has no effect on the frame in flight.
- tx_enable falling mid-frame: the frame completes normally; no new pop follows.
- Reset mid-frame: uart_tx returns to 1 immediately. The partially sent byte is lost and is not re-popped.
- uart_tx is driven from a flop (glitch-free).

Optional Feature:
- Macro FIFO_UART_TX_PARITY_EN.
- Defined:
  - An even-parity bit (XOR of all data bits) is inserted between the last data bit and the stop bit, lasting CYCLES_PER_BIT cycles (state PARITY).
  - Frame length is (PAYLOAD_BITS+3)*CYCLES_PER_BIT.
- Undefined:
  - PARITY state and logic are absent; frame is 8N1 as above.

Test Plan:
- Bench config: CLK_FREQ=8, BIT_RATE=1, i.e. CYCLES_PER_BIT=8.
- Reset with fifo_empty=1 -> uart_tx=1, busy=0, fifo_read=0; lines stay constant for 100 cycles.
- Single byte 0x70 in FIFO, tx_enable=1:
  - fifo_read pulses for 1 cycle.
  - uart_tx shows start 0, then bits 0,0,0,0,1,1,1,0, then stop 1, each 8 cycles.
  - busy falls after 80 line cycles.
- Bytes 0x70 and 0x71 queued:
  - Two pops, two frames.
  - Gap between the stop end of frame 1 and the start of frame 2 is exactly 3 cycles.
  - Second frame data bits are 1,0,0,0,1,1,1,0.
- tx_enable dropped during frame 1 of 0x70/0x72 -> frame 1 completes; no second fifo_read. Raising tx_enable -> 0x72 is sent.
- Reset asserted mid-DATA of 0x71 -> uart_tx=1 the same cycle and busy=0. After release with the FIFO empty, there is no further activity.
- With FIFO_UART_TX_PARITY_EN defined, byte 0x70 (three 1s) -> parity bit = 1 for 8 cycles before stop; total frame 88 cycles.

Source files
------------

// File: rtl/fifo_uart_tx.sv
// FIFO-draining UART transmitter: pops one byte per frame and sends it 8N1, LSB first.
// Define FIFO_UART_TX_PARITY_EN to insert an even-parity bit between the data and stop bits.
module fifo_uart_tx #(
    parameter int CLK_FREQ     = 25000000,
    parameter int BIT_RATE     = 115200,
    parameter int PAYLOAD_BITS = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    tx_enable,
    input  logic                    fifo_empty,
    output logic                    fifo_read,
    input  logic [PAYLOAD_BITS-1:0] fifo_read_data,
    output logic                    uart_tx,
    output logic                    busy,
    output logic [2:0]              debug_state
);

    localparam int CYCLES_PER_BIT = CLK_FREQ / BIT_RATE;
    localparam int CNT_W          = $clog2(CYCLES_PER_BIT);
    localparam int IDX_W          = (PAYLOAD_BITS > 1) ? $clog2(PAYLOAD_BITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAYLOAD_BITS - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        POP    = 3'd1,
        LOAD   = 3'd2,
        START  = 3'd3,
        DATA   = 3'd4,
`ifdef FIFO_UART_TX_PARITY_EN
        PARITY = 3'd5,
`endif
        STOP   = 3'd6
    } state_t;

    state_t                  state, state_next;
    logic [CNT_W-1:0]        cnt, cnt_next;
    logic [IDX_W-1:0]        idx, idx_next;
    logic [PAYLOAD_BITS-1:0] shift, shift_next;
    logic                    tx_reg, tx_next;
    logic                    bit_end;
`ifdef FIFO_UART_TX_PARITY_EN
    logic                    parity, parity_next;
`endif

    assign bit_end = (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            cnt    <= '0;
            idx    <= '0;
            shift  <= '0;
            tx_reg <= 1'b1;
`ifdef FIFO_UART_TX_PARITY_EN
            parity <= 1'b0;
`endif
        end else begin
            state  <= state_next;
            cnt    <= cnt_next;
            idx    <= idx_next;
            shift  <= shift_next;
            tx_reg <= tx_next;
`ifdef FIFO_UART_TX_PARITY_EN
            parity <= parity_next;
`endif
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        idx_next   = idx;
        shift_next = shift;
`ifdef FIFO_UART_TX_PARITY_EN
        parity_next = parity;
`endif
        case (state)
            IDLE: begin
                if (tx_enable && !fifo_empty) state_next = POP;
            end
            POP: state_next = LOAD;
            LOAD: begin
                // Read data is valid the cycle after the pop strobe.
                shift_next = fifo_read_data;
                cnt_next   = '0;
                idx_next   = '0;
`ifdef FIFO_UART_TX_PARITY_EN
                parity_next = ^fifo_read_data;
`endif
                state_next = START;
            end
            START: begin
                if (bit_end) begin
                    cnt_next   = '0;
                    state_next = DATA;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_next   = '0;
                    shift_next = shift >> 1;
                    if (idx == IDX_LAST) begin
`ifdef FIFO_UART_TX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end else begin
                        idx_next = idx + IDX_W'(1);
                    end
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
`ifdef FIFO_UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    cnt_next   = '0;
                    state_next = STOP;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    cnt_next   = '0;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase

        // Line level is computed from the next state so the flop lines up with the state register.
        tx_next = 1'b1;
        case (state_next)
            START: tx_next = 1'b0;
            DATA:  tx_next = shift_next[0];
`ifdef FIFO_UART_TX_PARITY_EN
            PARITY: tx_next = parity_next;
`endif
            default: tx_next = 1'b1;
        endcase
    end

    assign uart_tx     = tx_reg;
    assign fifo_read   = (state == POP);
    assign busy        = (state != IDLE);
    assign debug_state = state;

endmodule
